fetch_stage: RTL and testbench

//  IF-stage producer feeding the IF/ID register: owns the PC, issues instruction-memory reads and

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF-stage producer: owns the PC, issues single-outstanding imem reads and presents pc/pc_4/instr_f to IF/ID.
// Optional FETCH_PERF_EN adds saturating perf_fetch/perf_drop counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1eceb000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] instr_f,
    output logic        instr_valid,
    output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [15:0] perf_drop
`endif
);

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        issue;
    logic [31:0] issue_addr;

    // Handshake: a request is a one-cycle imem_rmask=F pulse with imem_addr; exactly one
    // imem_resp answers it at least one cycle later. Redirect outranks resp and stall.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        issue       = 1'b0;
        issue_addr  = pc_q;
        instr_valid = 1'b0;
        instr_f     = NOP_INSTR;
        case (state_q)
            ISSUE: begin
                issue      = 1'b1;
                issue_addr = redirect ? redirect_pc : pc_q;
                state_d    = WAIT;
            end
            WAIT: begin
                if (imem_resp) begin
                    if (redirect) begin
                        issue      = 1'b1;
                        issue_addr = redirect_pc;
                    end else begin
                        instr_valid = 1'b1;
                        instr_f     = imem_rdata;
                        if (!stall) begin
                            issue      = 1'b1;
                            issue_addr = pc_q + 32'd4;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                instr_f     = hold_q;
                if (redirect) begin
                    issue      = 1'b1;
                    issue_addr = redirect_pc;
                    state_d    = WAIT;
                end else if (!stall) begin
                    issue      = 1'b1;
                    issue_addr = pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            DISCARD: begin
                if (redirect) pc_d = redirect_pc;
                if (imem_resp) begin
                    issue      = 1'b1;
                    issue_addr = redirect ? redirect_pc : pc_q;
                    state_d    = WAIT;
                end
            end
            default: state_d = ISSUE;
        endcase
        if (issue) pc_d = issue_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // ISSUE is the reset state, so the request pulse must be masked while reset is held.
    assign imem_rmask = (issue && rst_n) ? 4'hF : 4'h0;
    assign imem_addr  = issue_addr;
    assign pc         = pc_q;
    assign pc_4       = pc_q + 32'd4;
    assign dbg_state  = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [15:0] perf_drop_q;
    logic        drop;

    assign drop = imem_resp && ((state_q == WAIT && redirect) || state_q == DISCARD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (instr_valid && !stall && perf_fetch_q != '1) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (drop && perf_drop_q != '1) perf_drop_q <= perf_drop_q + 16'd1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_drop  = perf_drop_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage: a behavioural imem and a fetch-stream reference model.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic [31:0] pc, pc_4, instr_f;
    logic        instr_valid;
    logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [15:0] perf_drop;
`endif

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
        .imem_resp(imem_resp), .pc(pc), .pc_4(pc_4), .instr_f(instr_f),
        .instr_valid(instr_valid), .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
        , .perf_fetch(perf_fetch), .perf_drop(perf_drop)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what the fetch stream should look like, in terms of program flow.
    logic        m_first = 1'b1;
    logic        m_busy  = 1'b0;
    logic        m_stale = 1'b0;
    logic        m_held  = 1'b0;
    logic [31:0] m_pc    = RESET_PC;

    // Behavioural instruction memory with one outstanding read.
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          lat_fix  = 1;
    logic        rel_pending = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1eceb000) return 32'hdeadbeef;
        return {a[15:0], a[31:16]} ^ 32'h13572468;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_resp = 1'b0;
        m_first = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_held = 1'b0; m_pc = RESET_PC;
        #1;
        chk("rst_rmask", {28'd0, imem_rmask}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr_f, NOP);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_pc4", pc_4, RESET_PC + 32'd4);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch, 32'd0);
        chk("rst_perf_drop", {16'd0, perf_drop}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        // Any abandoned read returns in the first cycle after release.
        if (mem_busy) mem_cnt = 1;
        rel_pending = 1'b1;
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ins;
        @(posedge clk);
        #1;
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 1'b0;
        end
        stall = st; redirect = rd; redirect_pc = rpc;
        imem_resp = 1'b0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                imem_resp = 1'b1;
                imem_rdata = mem_word(mem_addr);
                mem_busy = 1'b0;
            end
        end
        #3;
        chk("pc", pc, m_pc);
        chk("pc_4", pc_4, m_pc + 32'd4);
        req = 1'b0; addr = m_pc; v = 1'b0; ins = NOP;
        if (m_first) begin
            req = 1'b1;
            addr = rd ? rpc : m_pc;
            m_first = 1'b0;
        end else if (m_held) begin
            v = 1'b1;
            ins = mem_word(m_pc);
            if (rd) begin req = 1'b1; addr = rpc; end
            else if (!st) begin req = 1'b1; addr = m_pc + 32'd4; end
        end else if (m_busy && imem_resp) begin
            if (rd) begin req = 1'b1; addr = rpc; end
            else if (m_stale) begin req = 1'b1; addr = m_pc; end
            else begin
                v = 1'b1;
                ins = mem_word(m_pc);
                if (!st) begin req = 1'b1; addr = m_pc + 32'd4; end
                else begin m_held = 1'b1; m_busy = 1'b0; end
            end
        end else if (m_busy && rd) begin
            m_pc = rpc;
            m_stale = 1'b1;
        end
        chk("rmask", {28'd0, imem_rmask}, req ? 32'hf : 32'h0);
        chk("valid", {31'd0, instr_valid}, {31'd0, v});
        chk("instr_f", instr_f, ins);
        if (req) chk("addr", imem_addr, addr);
        if (req) begin
            m_busy = 1'b1; m_stale = 1'b0; m_held = 1'b0; m_pc = addr;
            mem_busy = 1'b1;
            mem_addr = addr;
            mem_cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
        end
    endtask

    initial begin
        logic        st, rd;
        logic [31:0] rpc;
        do_reset();
        lat_fix = 1;
        step(1'b0, 1'b0, '0);
        chk("first_addr", imem_addr, 32'h1eceb000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);
            chk("hold_instr", instr_f, 32'hdeadbeef);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            if (i > 0) chk("hold_noreq", {28'd0, imem_rmask}, 32'd0);
        end
        step(1'b0, 1'b0, '0);
        chk("unstall_addr", imem_addr, 32'h1eceb004);
        lat_fix = 3;
        step(1'b0, 1'b0, '0);
        chk("seq_addr", imem_addr, 32'h1eceb008);
        lat_fix = 1;
        step(1'b0, 1'b1, 32'h1eceb100);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_redir_addr", imem_addr, 32'h1eceb100);
        step(1'b1, 1'b1, 32'h1eceb200);
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("drop_addr", imem_addr, 32'h1eceb200);
        step(1'b0, 1'b0, '0);
        chk("after_drop_pc", pc, 32'h1eceb200);
        step(1'b0, 1'b1, 32'hfffffffc);
        step(1'b0, 1'b0, '0);
        chk("wrap_pc4", pc_4, 32'h00000000);
        chk("wrap_addr", imem_addr, 32'h00000000);
        lat_fix = 3;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        do_reset();
        step(1'b0, 1'b0, '0);
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        lat_fix = 0;
        for (int n = 0; n < 1500; n++) begin
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
            step(st, rd, rpc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
